// File: rtl/board_state.sv
// Board owner for the 6x6 pair game: colour store, removed/selected masks and cursor.
// Shuffles the starting layout with an LFSR after reset, then follows the matcher's ms/mf results.
module board_state #(
   parameter logic [15:0] SEED           = 16'hACE1,
   parameter int          SHUFFLE_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_sel,
   input  logic        en_input,
   input  logic        ms,
   input  logic        mf,
   input  logic [5:0]  addr,
   output logic [35:0] sel_bus,
   output logic [35:0] hidden_bus,
   output logic [2:0]  r,
   output logic [2:0]  g,
   output logic [1:0]  b,
   output logic [5:0]  cursor,
   output logic        busy,
   output logic        won,
   output logic [4:0]  pairs_left
);

   typedef enum logic [1:0] {S_SHUFFLE, S_PLAY, S_WON} state_t;

   state_t      r_state;
   logic [7:0]  r_colour [36];
   logic [15:0] r_lfsr;
   logic [31:0] r_step;
   logic [5:0]  r_j;
   logic [5:0]  r_cursor;
   logic [35:0] r_sel;
   logic [35:0] r_hidden;
   logic [4:0]  r_pairs;
   logic        r_won;
   logic        r_busy;
   logic        r_msQ;
   logic        r_mfQ;

   logic [15:0] w_lfsrNext;
   logic [5:0]  w_k;
   logic [5:0]  w_jNext;
   logic        w_msRise;
   logic        w_mfRise;
   logic [35:0] w_curBit;
   logic [5:0]  w_selCount;
   logic [2:0]  w_col;
   logic [5:0]  w_cursorNext;

   // Swap partner comes from the freshly advanced LFSR value, folded into 0..35.
   assign w_lfsrNext = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
   assign w_k        = (w_lfsrNext[5:0] >= 6'd36) ? (w_lfsrNext[5:0] - 6'd36) : w_lfsrNext[5:0];
   assign w_jNext    = (r_j == 6'd35) ? 6'd0 : (r_j + 6'd1);
   assign w_msRise   = ms & ~r_msQ;
   assign w_mfRise   = mf & ~r_mfQ;
   assign w_curBit   = 36'd1 << r_cursor;
   assign w_selCount = 6'($countones(r_sel));
   assign w_col      = 3'(r_cursor % 6'd6);

   // One move per cycle, up > down > left > right, saturating at the edges.
   always_comb begin
      w_cursorNext = r_cursor;
      if (btn_up) begin
         if (r_cursor >= 6'd6) w_cursorNext = r_cursor - 6'd6;
      end else if (btn_down) begin
         if (r_cursor < 6'd30) w_cursorNext = r_cursor + 6'd6;
      end else if (btn_left) begin
         if (w_col != 3'd0) w_cursorNext = r_cursor - 6'd1;
      end else if (btn_right) begin
         if (w_col != 3'd5) w_cursorNext = r_cursor + 6'd1;
      end
   end

   always_comb begin
      {r, g, b} = 8'h00;
      if (addr < 6'd36) {r, g, b} = r_colour[addr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 36; i++) r_colour[i] <= 8'((i >> 1) * 14 + 15);
         r_state  <= (SHUFFLE_CYCLES == 0) ? S_PLAY : S_SHUFFLE;
         r_busy   <= (SHUFFLE_CYCLES != 0);
         r_lfsr   <= SEED;
         r_step   <= 32'd0;
         r_j      <= 6'd0;
         r_cursor <= 6'd0;
         r_sel    <= 36'd0;
         r_hidden <= 36'd0;
         r_pairs  <= 5'd18;
         r_won    <= 1'b0;
         r_msQ    <= 1'b0;
         r_mfQ    <= 1'b0;
      end else begin
         r_msQ <= ms;
         r_mfQ <= mf;
         case (r_state)
            S_SHUFFLE: begin
               r_lfsr         <= w_lfsrNext;
               r_colour[r_j]  <= r_colour[w_k];
               r_colour[w_k]  <= r_colour[r_j];
               r_j            <= w_jNext;
               r_step         <= r_step + 32'd1;
               if (r_step == 32'(SHUFFLE_CYCLES - 1)) begin
                  r_state <= S_PLAY;
                  r_busy  <= 1'b0;
               end
            end
            S_PLAY: begin
               r_cursor <= w_cursorNext;
               if (w_msRise) begin
                  r_hidden <= r_hidden | r_sel;
                  r_sel    <= 36'd0;
                  if (w_selCount == 6'd2) begin
                     r_pairs <= r_pairs - 5'd1;
                     if (r_pairs == 5'd1) begin
                        r_state <= S_WON;
                        r_won   <= 1'b1;
                     end
                  end
               end else if (w_mfRise) begin
                  r_sel <= 36'd0;
               end else if (btn_sel && en_input) begin
                  if ((r_hidden & w_curBit) != 36'd0) begin
                     r_sel <= r_sel;
                  end else if ((r_sel & w_curBit) != 36'd0) begin
                     r_sel <= r_sel & ~w_curBit;
                  end else if (w_selCount < 6'd2) begin
                     r_sel <= r_sel | w_curBit;
                  end
               end
            end
            default: begin
               r_state <= S_WON;
            end
         endcase
      end
   end

   assign sel_bus    = r_sel;
   assign hidden_bus = r_hidden;
   assign cursor     = r_cursor;
   assign busy       = r_busy;
   assign won        = r_won;
   assign pairs_left = r_pairs;

endmodule

// File: tb/tb_board_state.sv
// Directed bench for board_state: an unshuffled instance for play logic and colour reads,
// and a shuffling instance for busy timing, colour conservation and reproducibility.
module tb_board_state;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0 = 1'b0, rst1 = 1'b0;
   logic        btnUp = 0, btnDown = 0, btnLeft = 0, btnRight = 0, btnSel = 0;
   logic        enInput = 1'b1, msIn = 1'b0, mfIn = 1'b0;
   logic [5:0]  addr0 = 6'd0, addr1 = 6'd0;

   logic [35:0] sel0, hidden0, sel1, hidden1;
   logic [2:0]  r0, g0, r1, g1;
   logic [1:0]  b0, b1;
   logic [5:0]  cursor0, cursor1;
   logic        busy0, busy1, won0, won1;
   logic [4:0]  pairs0, pairs1;

   int total = 0;
   int bad = 0;
   int tbCursor = 0;
   logic [7:0] layoutA [36];
   logic [7:0] layoutB [36];

   board_state #(.SEED(16'hACE1), .SHUFFLE_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst0),
      .btn_up(btnUp), .btn_down(btnDown), .btn_left(btnLeft), .btn_right(btnRight),
      .btn_sel(btnSel), .en_input(enInput), .ms(msIn), .mf(mfIn), .addr(addr0),
      .sel_bus(sel0), .hidden_bus(hidden0), .r(r0), .g(g0), .b(b0),
      .cursor(cursor0), .busy(busy0), .won(won0), .pairs_left(pairs0)
   );

   board_state #(.SEED(16'hACE1), .SHUFFLE_CYCLES(256)) dut1 (
      .clk(clk), .rst(rst1),
      .btn_up(1'b0), .btn_down(1'b0), .btn_left(1'b0), .btn_right(1'b0),
      .btn_sel(1'b0), .en_input(1'b0), .ms(1'b0), .mf(1'b0), .addr(addr1),
      .sel_bus(sel1), .hidden_bus(hidden1), .r(r1), .g(g1), .b(b1),
      .cursor(cursor1), .busy(busy1), .won(won1), .pairs_left(pairs1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Pulses the buttons {up,down,left,right,sel} for exactly one clock.
   task automatic applyStimulus(input logic [4:0] btns);
      {btnUp, btnDown, btnLeft, btnRight, btnSel} = btns;
      tick();
      {btnUp, btnDown, btnLeft, btnRight, btnSel} = 5'b0;
   endtask

   task automatic moveTo(input int target);
      while (tbCursor / 6 > target / 6) begin applyStimulus(5'b10000); tbCursor -= 6; end
      while (tbCursor / 6 < target / 6) begin applyStimulus(5'b01000); tbCursor += 6; end
      while (tbCursor % 6 > target % 6) begin applyStimulus(5'b00100); tbCursor -= 1; end
      while (tbCursor % 6 < target % 6) begin applyStimulus(5'b00010); tbCursor += 1; end
   endtask

   task automatic shuffleRun(input string tag);
      int n;
      n = 0;
      while (busy1 === 1'b1 && n < 1000) begin
         tick();
         n++;
      end
      checkOutput(tag, 64'(n), 64'd256);
   endtask

   task automatic readLayout(output logic [7:0] lay [36]);
      for (int i = 0; i < 36; i++) begin
         addr1 = 6'(i);
         #1;
         lay[i] = {r1, g1, b1};
      end
   endtask

   initial begin
      int cnt;
      int diffs;

      // Unshuffled instance: reset values and identity colour layout.
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      checkOutput("rst0 busy", 64'(busy0), 64'd0);
      checkOutput("rst0 sel", 64'(sel0), 64'd0);
      checkOutput("rst0 hidden", 64'(hidden0), 64'd0);
      checkOutput("rst0 cursor", 64'(cursor0), 64'd0);
      checkOutput("rst0 pairs", 64'(pairs0), 64'd18);
      checkOutput("rst0 won", 64'(won0), 64'd0);
      for (int a = 0; a < 36; a++) begin
         addr0 = 6'(a);
         #1;
         checkOutput($sformatf("colour[%0d]", a), 64'({r0, g0, b0}), 64'((a / 2) * 14 + 15));
      end
      addr0 = 6'd0;  #1; checkOutput("colour 0 const", 64'({r0, g0, b0}), 64'h0F);
      addr0 = 6'd35; #1; checkOutput("colour 35 const", 64'({r0, g0, b0}), 64'hFD);
      addr0 = 6'd40; #1; checkOutput("colour oob", 64'({r0, g0, b0}), 64'h00);

      // Shuffling instance: busy window, colour multiset, reproducibility.
      rst1 = 1'b1;
      tick();
      rst1 = 1'b0;
      checkOutput("rst1 busy", 64'(busy1), 64'd1);
      shuffleRun("busy cycles");
      readLayout(layoutA);
      for (int p = 0; p < 18; p++) begin
         cnt = 0;
         for (int i = 0; i < 36; i++) if (layoutA[i] == 8'(p * 14 + 15)) cnt++;
         checkOutput($sformatf("colour count %0d", p), 64'(cnt), 64'd2);
      end
      diffs = 0;
      for (int i = 0; i < 36; i++) if (layoutA[i] != 8'((i / 2) * 14 + 15)) diffs++;
      checkOutput("layout shuffled", 64'(diffs != 0), 64'd1);
      rst1 = 1'b1; tick(); rst1 = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      rst1 = 1'b1; tick(); rst1 = 1'b0;
      shuffleRun("busy cycles again");
      readLayout(layoutB);
      diffs = 0;
      for (int i = 0; i < 36; i++) if (layoutA[i] != layoutB[i]) diffs++;
      checkOutput("layout repeat", 64'(diffs), 64'd0);

      // Cursor saturation and travel.
      applyStimulus(5'b00100); checkOutput("cursor left sat", 64'(cursor0), 64'd0);
      applyStimulus(5'b10000); checkOutput("cursor up sat", 64'(cursor0), 64'd0);
      for (int i = 0; i < 7; i++) applyStimulus(5'b00010);
      checkOutput("cursor right x7", 64'(cursor0), 64'd5);
      for (int i = 0; i < 7; i++) applyStimulus(5'b01000);
      checkOutput("cursor down x7", 64'(cursor0), 64'd35);
      tbCursor = 35;
      moveTo(0);
      checkOutput("cursor home", 64'(cursor0), 64'd0);

      // Selection rules.
      applyStimulus(5'b00001);
      applyStimulus(5'b00010); tbCursor = 1;
      applyStimulus(5'b00001);
      checkOutput("sel 0,1", 64'(sel0), 64'h3);
      applyStimulus(5'b00010); tbCursor = 2;
      applyStimulus(5'b00001);
      checkOutput("sel third ignored", 64'(sel0), 64'h3);
      applyStimulus(5'b00100); tbCursor = 1;
      applyStimulus(5'b00001);
      checkOutput("deselect 1", 64'(sel0), 64'h1);
      enInput = 1'b0;
      applyStimulus(5'b00001);
      checkOutput("sel en_input=0", 64'(sel0), 64'h1);
      enInput = 1'b1;
      applyStimulus(5'b00001);
      checkOutput("reselect 1", 64'(sel0), 64'h3);

      // Held ms removes the pair exactly once.
      msIn = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      msIn = 1'b0;
      tick();
      checkOutput("ms hidden", 64'(hidden0), 64'h3);
      checkOutput("ms sel", 64'(sel0), 64'h0);
      checkOutput("ms pairs", 64'(pairs0), 64'd17);
      applyStimulus(5'b00001);
      checkOutput("sel hidden ignored", 64'(sel0), 64'h0);

      // Select uses the pre-move cursor; up beats right.
      applyStimulus(5'b00010); tbCursor = 2;
      applyStimulus(5'b00011); tbCursor = 3;
      checkOutput("sel pre-move", 64'(sel0), 64'h4);
      checkOutput("cursor after sel+right", 64'(cursor0), 64'd3);
      applyStimulus(5'b10010);
      checkOutput("priority up>right", 64'(cursor0), 64'd3);
      applyStimulus(5'b00001);
      checkOutput("sel 2,3", 64'(sel0), 64'hC);
      mfIn = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      mfIn = 1'b0;
      tick();
      checkOutput("mf sel", 64'(sel0), 64'h0);
      checkOutput("mf hidden", 64'(hidden0), 64'h3);
      checkOutput("mf pairs", 64'(pairs0), 64'd17);

      // Clear the rest of the board.
      for (int p = 1; p < 18; p++) begin
         moveTo(2 * p);
         applyStimulus(5'b00001);
         moveTo(2 * p + 1);
         applyStimulus(5'b00001);
         msIn = 1'b1;
         tick();
         checkOutput($sformatf("pairs after %0d", p), 64'(pairs0), 64'(17 - p));
         checkOutput($sformatf("won after %0d", p), 64'(won0), 64'(p == 17));
         tick();
         msIn = 1'b0;
         tick();
      end
      checkOutput("won hidden", 64'(hidden0), 64'hF_FFFF_FFFF);

      // WON freezes everything.
      applyStimulus(5'b00100);
      applyStimulus(5'b00001);
      msIn = 1'b1; tick(); tick(); msIn = 1'b0; tick();
      checkOutput("frozen cursor", 64'(cursor0), 64'd35);
      checkOutput("frozen sel", 64'(sel0), 64'h0);
      checkOutput("frozen pairs", 64'(pairs0), 64'd0);
      checkOutput("frozen won", 64'(won0), 64'd1);

      // Reset restarts fully, including from mid-game.
      rst0 = 1'b1; tick(); rst0 = 1'b0;
      checkOutput("restart won", 64'(won0), 64'd0);
      checkOutput("restart hidden", 64'(hidden0), 64'h0);
      checkOutput("restart pairs", 64'(pairs0), 64'd18);
      checkOutput("restart cursor", 64'(cursor0), 64'd0);
      applyStimulus(5'b00010);
      applyStimulus(5'b00001);
      checkOutput("midgame sel", 64'(sel0), 64'h2);
      rst0 = 1'b1; tick(); rst0 = 1'b0;
      checkOutput("midgame rst sel", 64'(sel0), 64'h0);
      checkOutput("midgame rst cursor", 64'(cursor0), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/board_state.md
Name: board_state

Overview:
- Owns the 6x6 card board for the game: per-cell colour store, removed ("hidden") mask, selection mask and player cursor.
- Sits directly upstream of the pair matcher:
  - drives sel_bus and hidden_bus into it;
  - answers its colour reads through addr -> r/g/b;
  - consumes its ms/mf results to remove or deselect the chosen pair.
- Also builds the shuffled starting layout after reset.

Parameters:
- SEED, 16'hACE1, nonzero initial value of the shuffle LFSR.
- SHUFFLE_CYCLES, 256, number of swap steps performed after reset; 0 means no shuffle.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle move pulses, already debounced.
- btn_sel  in  1  single-cycle select/toggle pulse.
- en_input  in  1  high = matcher idle, selection changes allowed.
- ms  in  1  match success, level, may stay high many cycles.
- mf  in  1  match failure, level, may stay high many cycles.
- addr  in  6  cell index for colour read (0..35, row*6+col).
- sel_bus  out  36  bit i = cell i selected.
- hidden_bus  out  36  bit i = cell i removed (empty).
- r  out  3  red of card at addr, combinational.
- g  out  3  green of card at addr, combinational.
- b  out  2  blue of card at addr, combinational.
- cursor  out  6  current cursor cell index.
- busy  out  1  high while shuffling.
- won  out  1  high once all 18 pairs are removed.
- pairs_left  out  5  remaining pairs, 18..0.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - sel_bus=0, hidden_bus=0, cursor=0, won=0, pairs_left=18, lfsr=SEED.
  - Cell i colour byte = {r,g,b} = (i>>1)*14+15, so pairs are adjacent, all 18 colours distinct and nonzero.
  - Step counter=0, swap index j=0.
  - Enters SHUFFLE, or PLAY if SHUFFLE_CYCLES==0.
  - busy=1 in the cycle after reset when SHUFFLE_CYCLES>0.
- Colour read: {r,g,b} = colour[addr], purely combinational, zero latency. addr >= 36 returns 0.
- State machine: SHUFFLE -> PLAY -> WON. Only rst leaves WON.
- SHUFFLE:
  - Each cycle:
    - LFSR advances (Galois, taps 16,14,13,11; mask 16'hB400).
    - k = lfsr[5:0]; if k >= 36 then k = k-36.
    - Swap colour[j] and colour[k]; a swap with k==j is a no-op.
    - j increments, wrapping 35 -> 0; step counter increments.
  - After SHUFFLE_CYCLES steps -> PLAY; busy drops the same edge.
  - All buttons, ms and mf are ignored.
- PLAY, cursor:
  - up/down change the row by ±1; left/right change the column by ±1.
  - The cursor saturates at the board edges; there is no wrap.
  - If several direction pulses arrive in one cycle, priority is up > down > left > right; only one move is applied.
- PLAY, btn_sel (processed only when en_input=1 and no ms/mf rising edge in the same cycle):
  - Cursor cell hidden -> ignored.
  - Cursor cell selected -> deselect it.
  - Fewer than 2 cells selected -> select the cursor cell.
  - Otherwise -> ignored.
- Move and select pulses in the same cycle: the select applies to the pre-move cursor.
- ms and mf are sampled into registers every cycle; actions happen on rising edges only.
- ms rising edge:
  - hidden_bus |= sel_bus; sel_bus = 0.
  - pairs_left decrements if popcount(sel_bus)==2; otherwise the ms edge only clears the selection.
  - When pairs_left reaches 0, state -> WON and won=1 on the same edge.
- mf rising edge: sel_bus = 0; hidden_bus unchanged.
- ms and mf rising in the same cycle: the ms action is taken.
- WON: outputs frozen, all inputs ignored.
- Reset at any point, including mid-shuffle or mid-match, fully restarts with the same SEED. Layout is deterministic per SEED.

Test Plan:
- SHUFFLE_CYCLES=0, rst 1 cycle -> busy=0. Sweep addr 0..35: addr 0,1 read 8'h0F; addr 34,35 read 8'hFD; addr 40 reads 0.
- SHUFFLE_CYCLES=256, SEED default -> busy high exactly 256 cycles. Colour multiset is unchanged: every byte appears exactly twice. A second reset reproduces the identical layout.
- Cursor: from 0, press left, then up -> cursor=0. Press right x7 -> 5. Press down x7 -> 35.
- Selection:
  - sel at 0 and 1 -> sel_bus=36'h3.
  - sel at 2 -> ignored.
  - sel at 1 again -> sel_bus=36'h1.
  - sel while en_input=0 -> no change.
- Hold ms high 10 cycles with cells 0 and 1 selected -> hidden_bus=36'h3, sel_bus=0, pairs_left=17, exactly one decrement. Then mf with cells 2 and 3 selected -> sel_bus=0, hidden_bus unchanged.
- Remove all 18 pairs via ms -> won=1 and pairs_left=0 on the 18th edge. Further buttons and ms have no effect. rst mid-game -> full restart with all fields at reset values.
